// File: rtl/tqvp_fir_pkg.sv
// TinyQV FIR peripheral shared definitions.
// Register addresses, bit positions, FSM encoding.
package tqvp_fir_pkg;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_SAMPLE = 4'h1;
  localparam logic [3:0] ADDR_STATUS = 4'h2;
  localparam logic [3:0] ADDR_OUT    = 4'h3;
  localparam logic [3:0] ADDR_COEF0  = 4'h4;

  localparam int CTRL_SRC   = 0;
  localparam int CTRL_SH_LO = 2;
  localparam int CTRL_SH_HI = 4;
  localparam int CTRL_CLR   = 7;

  localparam int ST_BUSY = 0;
  localparam int ST_OVF  = 1;
  localparam int ST_DROP = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/tqvp_fir_mac_unit.sv
// Serial multiply-accumulate datapath.
// Result is the shifted accumulator, saturated to 8 bits.
module tqvp_fir_mac_unit #(
  parameter int ACC_W = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] shift,
  output logic [7:0] result,
  output logic       ovf
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] shifted;
  logic [15:0]      prod;

  assign prod = 16'(a) * 16'(b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  assign shifted = acc >> shift;
  assign ovf     = |shifted[ACC_W-1:8];
  assign result  = ovf ? 8'hFF : shifted[7:0];

endmodule

// File: rtl/tqvp_fir_mac.sv
// TAPS-tap FIR byte peripheral on the TinyQV bus.
// Holds registers, sample history, sequencing FSM and read mux.
module tqvp_fir_mac
  import tqvp_fir_pkg::*;
#(
  parameter int TAPS  = 8,
  parameter int ACC_W = 16 + clog2(TAPS)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int         KW    = clog2(TAPS);
  localparam logic [3:0] NTAPS = 4'(TAPS);

  logic [7:0]    hist [TAPS];
  logic [7:0]    coef [TAPS];
  state_t        state;
  logic [KW-1:0] k;
  logic          src;
  logic [2:0]    shift;
  logic [7:0]    out_q;
  logic          ovf;
  logic          drop;

  logic          busy;
  logic          wr_ctrl;
  logic          wr_sample;
  logic          wr_status;
  logic          wr_coef;
  logic          is_coef;
  logic          start;
  logic          clr_hist;
  logic [3:0]    coef_idx;
  logic [7:0]    sample;
  logic [7:0]    mac_result;
  logic          mac_ovf;

  assign busy      = (state != IDLE);
  assign coef_idx  = address - ADDR_COEF0;
  assign is_coef   = (address >= ADDR_COEF0)
                   && (coef_idx < NTAPS);
  assign wr_ctrl   = data_write && (address == ADDR_CTRL);
  assign wr_sample = data_write && (address == ADDR_SAMPLE);
  assign wr_status = data_write && (address == ADDR_STATUS);
  assign wr_coef   = data_write && is_coef;
  assign start     = wr_sample && !busy;
  assign clr_hist  = wr_ctrl && data_in[CTRL_CLR];
  assign sample    = src ? ui_in : data_in;
  assign uo_out    = out_q;

  tqvp_fir_mac_unit #(
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .en     (state == MAC),
    .a      (hist[k]),
    .b      (coef[k]),
    .shift  (shift),
    .result (mac_result),
    .ovf    (mac_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      src   <= 1'b0;
      shift <= 3'(KW);
      out_q <= '0;
      ovf   <= 1'b0;
      drop  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= 8'd1;
      end
    end else begin
      if (wr_ctrl) begin
        src   <= data_in[CTRL_SRC];
        shift <= data_in[CTRL_SH_HI:CTRL_SH_LO];
      end
      if (wr_coef) coef[coef_idx[KW-1:0]] <= data_in;
      if (wr_status && data_in[ST_OVF])  ovf  <= 1'b0;
      if (wr_status && data_in[ST_DROP]) drop <= 1'b0;
      // Sets are placed after the W1C clears so they win.
      if (wr_sample && busy) drop <= 1'b1;
      if (clr_hist) begin
        for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              for (int i = TAPS - 1; i > 0; i--)
                hist[i] <= hist[i-1];
              hist[0] <= sample;
              k       <= '0;
              state   <= MAC;
            end
          end
          MAC: begin
            k <= k + 1'b1;
            if (k == KW'(TAPS - 1)) state <= DONE;
          end
          DONE: begin
            out_q <= mac_result;
            if (mac_ovf) ovf <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    data_out = '0;
    unique case (1'b1)
      is_coef:
        data_out = coef[coef_idx[KW-1:0]];
      address == ADDR_CTRL:
        data_out = {3'b0, shift, 1'b0, src};
      address == ADDR_SAMPLE:
        data_out = hist[0];
      address == ADDR_STATUS:
        data_out = {5'b0, drop, ovf, busy};
      address == ADDR_OUT:
        data_out = out_q;
      default: data_out = '0;
    endcase
  end

endmodule

// File: tb/tb_tqvp_fir_mac.sv
// Scoreboard bench for tqvp_fir_mac with a queue-based FIR model.
// Directed scenarios followed by randomized sample/coef traffic.
module tb_tqvp_fir_mac;
  import tqvp_fir_pkg::*;

  localparam int TAPS = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uo_out;
  logic [3:0] address = '0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;

  tqvp_fir_mac #(.TAPS(TAPS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  val;
    int unsigned due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int          m_h [TAPS];
  int          m_c [TAPS];
  int          m_shift;
  bit          m_src;
  int          m_out;
  int          prev_out;
  bit          m_ovf;
  bit          prev_ovf;
  bit          m_drop;
  int unsigned busy_until;

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: OUT must hold the expected value at its due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      if (cyc >= sb[0].due) begin
        if (cyc == sb[0].due) chk("out", uo_out, sb[0].val);
        else chk("out_missed", uo_out, ~sb[0].val);
        void'(sb.pop_front());
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      m_h[i] = 0;
      m_c[i] = 1;
    end
    m_shift    = 3;
    m_src      = 1'b0;
    m_out      = 0;
    m_ovf      = 1'b0;
    m_drop     = 1'b0;
    busy_until = 0;
  endtask

  task automatic sample_wr(input logic [7:0] d);
    int sum;
    int r;
    @(negedge clk);
    address    = ADDR_SAMPLE;
    data_in    = d;
    data_write = 1'b1;
    if (cyc >= busy_until) begin
      for (int i = TAPS - 1; i > 0; i--) m_h[i] = m_h[i-1];
      m_h[0] = m_src ? int'(ui_in) : int'(d);
      sum = 0;
      for (int i = 0; i < TAPS; i++) sum += m_h[i] * m_c[i];
      r = sum >> m_shift;
      prev_out = m_out;
      prev_ovf = m_ovf;
      m_out = (r > 255) ? 255 : r;
      if (r > 255) m_ovf = 1'b1;
      busy_until = cyc + TAPS + 2;
      sb.push_back('{val: 8'(m_out), due: cyc + TAPS + 2});
    end else begin
      m_drop = 1'b1;
    end
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address    = a;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    @(negedge clk);
    address    = ADDR_CTRL;
    data_in    = d;
    data_write = 1'b1;
    m_src   = d[0];
    m_shift = int'(d[4:2]);
    if (d[7]) begin
      for (int i = 0; i < TAPS; i++) m_h[i] = 0;
      if (cyc < busy_until) begin
        sb[$].val  = 8'(prev_out);
        m_out      = prev_out;
        m_ovf      = prev_ovf;
        busy_until = 0;
      end
    end
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rdchk(input string nm,
                       input logic [3:0] a,
                       input logic [7:0] e);
    @(negedge clk);
    address = a;
    #1;
    chk(nm, data_out, e);
  endtask

  task automatic rdnow(input string nm,
                       input logic [3:0] a,
                       input logic [7:0] e);
    address = a;
    #1;
    chk(nm, data_out, e);
  endtask

  task automatic wait_idle();
    while (cyc < busy_until) @(negedge clk);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain", 8'(sb.size()), 8'd0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    chk("rst_uo", uo_out, 8'h00);
    rdchk("rst_ctrl", ADDR_CTRL, 8'h0C);
    rdchk("rst_status", ADDR_STATUS, 8'h00);
    rdchk("rst_out", ADDR_OUT, 8'h00);
    rdchk("rst_sample", ADDR_SAMPLE, 8'h00);
    rdchk("rst_coef0", ADDR_COEF0, 8'h01);
    rdchk("rst_coef7", 4'hB, 8'h01);
    rdchk("rst_unmapped", 4'hC, 8'h00);

    // Moving average of a constant.
    for (int i = 0; i < 8; i++) begin
      wait_idle();
      sample_wr(8'h40);
    end
    for (int i = 0; i < 10; i++) begin
      address = ADDR_STATUS;
      #1;
      chk("busy_win", {7'b0, data_out[0]}, (i < 9) ? 8'd1 : 8'd0);
      @(negedge clk);
    end
    rdchk("avg_out", ADDR_OUT, 8'h40);

    // Saturation and OVF W1C.
    wait_idle();
    ctrl_wr(8'h00);
    wr(ADDR_COEF0, 8'd2);
    m_c[0] = 2;
    for (int i = 1; i < TAPS; i++) begin
      wr(ADDR_COEF0 + 4'(i), 8'd0);
      m_c[i] = 0;
    end
    rdchk("coef1_rb", 4'h5, 8'h00);
    sample_wr(8'h90);
    wait_idle();
    rdchk("ovf_set", ADDR_STATUS, 8'h02);
    wr(ADDR_STATUS, 8'h02);
    m_ovf = 1'b0;
    rdchk("ovf_w1c", ADDR_STATUS, 8'h00);

    // Write during MAC is dropped.
    wait_idle();
    sample_wr(8'h11);
    @(negedge clk);
    sample_wr(8'h22);
    wait_idle();
    rdchk("drop_h0", ADDR_SAMPLE, 8'h11);
    rdchk("drop_set", ADDR_STATUS, 8'h04);
    wr(ADDR_STATUS, 8'h04);
    m_drop = 1'b0;

    // Sample taken from ui_in.
    ctrl_wr(8'h01);
    ui_in = 8'h22;
    sample_wr(8'h99);
    wait_idle();
    rdchk("src_ui", ADDR_SAMPLE, 8'h22);
    rdchk("src_ctrl", ADDR_CTRL, 8'h01);
    ctrl_wr(8'h00);

    // Clear mid-MAC aborts, OUT kept.
    sample_wr(8'h30);
    repeat (2) @(negedge clk);
    ctrl_wr(8'h80);
    address = ADDR_STATUS;
    #1;
    chk("clr_busy", data_out, 8'h00);
    rdchk("clr_out", ADDR_OUT, 8'(m_out));
    rdchk("clr_hist", ADDR_SAMPLE, 8'h00);
    drain();

    // Async reset mid-MAC.
    sample_wr(8'h55);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    chk("arst_uo", uo_out, 8'h00);
    rdnow("arst_ctrl", ADDR_CTRL, 8'h0C);
    rdnow("arst_status", ADDR_STATUS, 8'h00);
    rdnow("arst_sample", ADDR_SAMPLE, 8'h00);
    rdnow("arst_out", ADDR_OUT, 8'h00);
    rdnow("arst_coef0", ADDR_COEF0, 8'h01);
    for (int a = 12; a < 16; a++)
      rdnow("arst_unmapped", 4'(a), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      int r;
      int kk;
      int v;
      r = $urandom_range(0, 9);
      if (r == 0) begin
        wait_idle();
        kk = $urandom_range(0, TAPS - 1);
        v  = $urandom_range(0, 255);
        wr(ADDR_COEF0 + 4'(kk), 8'(v));
        m_c[kk] = v;
      end else if (r == 1) begin
        wait_idle();
        v = $urandom_range(0, 7);
        ctrl_wr({3'b0, 3'(v), 2'b0});
      end else begin
        repeat ($urandom_range(0, 11)) @(negedge clk);
        sample_wr(8'($urandom));
      end
    end
    wait_idle();
    drain();
    st = {5'b0, m_drop, m_ovf, 1'b0};
    rdchk("rand_status", ADDR_STATUS, st);
    rdchk("rand_h0", ADDR_SAMPLE, 8'(m_h[0]));
    rdchk("rand_out", ADDR_OUT, 8'(m_out));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
